// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: shared widths, EXE_CMD encodings and the control-field bundle for the ID/EX register
package id_ex_stage_reg_pkg;
   localparam int WORD_W  = 32;
   localparam int REG_AW  = 4;
   localparam int IMM24_W = 24;
   localparam int SHIFT_W = 12;
   typedef enum logic [3:0] {
      EXE_NOP = 4'b0000,
      EXE_MOV = 4'b0001,
      EXE_ADD = 4'b0010,
      EXE_ADC = 4'b0011,
      EXE_SUB = 4'b0100,
      EXE_SBC = 4'b0101,
      EXE_AND = 4'b0110,
      EXE_ORR = 4'b0111,
      EXE_EOR = 4'b1000,
      EXE_MVN = 4'b1001
   } exe_cmd_e;
   typedef struct packed {
      logic valid;
      logic wb_en;
      logic mem_r_en;
      logic mem_w_en;
      logic b;
      logic s;
   } ctrl_t;
   // An empty slot must never carry side-effecting enables into EX.
   function automatic ctrl_t gate_ctrl(input ctrl_t c);
      return c.valid ? c : '0;
   endfunction
endpackage

// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: ID-side inputs, stall/flush controls and EX-side registered outputs
//   master: decode/hazard side (drives *_in, freeze, flush; reads *_out)
//   slave : the stage register (reads *_in, freeze, flush; drives *_out)
interface id_ex_stage_reg_if #(
   parameter int WORD_W  = id_ex_stage_reg_pkg::WORD_W,
   parameter int REG_AW  = id_ex_stage_reg_pkg::REG_AW,
   parameter int IMM24_W = id_ex_stage_reg_pkg::IMM24_W,
   parameter int SHIFT_W = id_ex_stage_reg_pkg::SHIFT_W
);
   logic               freeze, flush, valid_in, valid_out;
   logic               WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in;
   logic               WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out;
   logic [3:0]         EXE_CMD_in, EXE_CMD_out;
   logic [WORD_W-1:0]  pc_in, val_rn_in, val_rm_in, pc_out, val_rn_out, val_rm_out;
   logic               imm_in, imm_out, carry_in, carry_out;
   logic [SHIFT_W-1:0] shift_operand_in, shift_operand_out;
   logic [IMM24_W-1:0] signed_imm24_in, signed_imm24_out;
   logic [REG_AW-1:0]  dest_in, dest_out;
   modport master (
      output freeze, flush, valid_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
             EXE_CMD_in, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
             signed_imm24_in, dest_in, carry_in,
      input  valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out,
             EXE_CMD_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
             signed_imm24_out, dest_out, carry_out
   );
   modport slave (
      input  freeze, flush, valid_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in,
             EXE_CMD_in, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
             signed_imm24_in, dest_in, carry_in,
      output valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out,
             EXE_CMD_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
             signed_imm24_out, dest_out, carry_out
   );
endinterface

// File: rtl/id_ex_stage_reg_pipe_field_reg.sv
// pipe_field_reg: W-bit register with async active-low reset, flush-to-zero (wins) and hold
//   clk, rst_n, flush, hold, d[W] -> q[W]
module pipe_field_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         hold,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (flush) q <= '0;
      else if (!hold) q <= d;
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with freeze (stall), flush (bubble) and per-slot valid
//   clk, rst_n (async, active-low); bus: id_ex_stage_reg_if.slave carrying all *_in/*_out fields
//   Optional ID_EX_PERF_CNT_EN: adds stall_cnt/bubble_cnt (32-bit, wrapping) outputs
module id_ex_stage_reg #(
   parameter int WORD_W  = id_ex_stage_reg_pkg::WORD_W,
   parameter int REG_AW  = id_ex_stage_reg_pkg::REG_AW,
   parameter int IMM24_W = id_ex_stage_reg_pkg::IMM24_W,
   parameter int SHIFT_W = id_ex_stage_reg_pkg::SHIFT_W
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef ID_EX_PERF_CNT_EN
   output logic [31:0]        stall_cnt,
   output logic [31:0]        bubble_cnt,
`endif
   id_ex_stage_reg_if.slave   bus
);
   import id_ex_stage_reg_pkg::*;
   localparam int DATA_W = 4 + 3*WORD_W + 1 + SHIFT_W + IMM24_W + REG_AW + 1;
   ctrl_t ctrl_d, ctrl_q;
   logic [DATA_W-1:0] data_d, data_q;
   assign ctrl_d = gate_ctrl('{bus.valid_in, bus.WB_EN_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in,
                               bus.B_in, bus.S_in});
   assign data_d = {bus.EXE_CMD_in, bus.pc_in, bus.val_rn_in, bus.val_rm_in, bus.imm_in,
                    bus.shift_operand_in, bus.signed_imm24_in, bus.dest_in, bus.carry_in};
   pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl (
      .clk(clk), .rst_n(rst_n), .flush(bus.flush), .hold(bus.freeze), .d(ctrl_d), .q(ctrl_q)
   );
   // Datapath is also flushed so a bubble is fully deterministic.
   pipe_field_reg #(.W(DATA_W)) u_data (
      .clk(clk), .rst_n(rst_n), .flush(bus.flush), .hold(bus.freeze), .d(data_d), .q(data_q)
   );
   assign {bus.valid_out, bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out,
           bus.B_out, bus.S_out} = ctrl_q;
   assign {bus.EXE_CMD_out, bus.pc_out, bus.val_rn_out, bus.val_rm_out, bus.imm_out,
           bus.shift_operand_out, bus.signed_imm24_out, bus.dest_out, bus.carry_out} = data_q;
`ifdef ID_EX_PERF_CNT_EN
   // A bubble enters EX on a flush or on an unfrozen load of an empty ID slot.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (bus.freeze && !bus.flush) stall_cnt <= stall_cnt + 32'd1;
         if (bus.flush || (!bus.freeze && !bus.valid_in)) bubble_cnt <= bubble_cnt + 32'd1;
      end
`endif
endmodule
